// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO commit unit and its wait counter.
package hilo_pkg;

    localparam int   HILO_WIDTH_DEF   = 32;
    localparam int   HILO_TIMEOUT_DEF = 64;
    localparam logic HILO_SEL_HI      = 1'b1;
    localparam logic HILO_SEL_LO      = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hilo_state_e;

    function automatic int hilo_ctr_width(input int timeout_cyc);
        return (timeout_cyc > 2) ? $clog2(timeout_cyc) : 1;
    endfunction

endpackage

// File: rtl/hilo_wait_ctr.sv
// Busy-cycle counter for an outstanding divide; o_tc flags the last
// busy cycle allowed before the divide is abandoned.
module hilo_wait_ctr
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYC = HILO_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int            CW     = hilo_ctr_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    // Clear has priority so a new divide always starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/hilo_commit_unit.sv
// Commits divider results into HI/LO, services MTHI/MTLO/MFHI/MFLO and stalls
// the pipeline while a divide is outstanding. Define HILO_FWD_EN to forward the
// committing value to MF on the commit cycle instead of stalling it.
module hilo_commit_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH       = HILO_WIDTH_DEF,
    parameter int TIMEOUT_CYC = HILO_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic [WIDTH-1:0] divu_q,
    input  logic [WIDTH-1:0] divu_r,
    input  logic             div_busy,
    input  logic             divu_busy,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_wdata,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             timeout_err
);

    hilo_state_e      r_state;
    hilo_state_e      w_state_nxt;
    logic             r_sel;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_timeout_err;

    logic             w_in_wait;
    logic             w_start;
    logic             w_busy_sel;
    logic             w_commit;
    logic             w_abort;
    logic             w_tc;
    logic             w_fwd;
    logic [WIDTH-1:0] w_new_hi;
    logic [WIDTH-1:0] w_new_lo;

    assign w_in_wait  = (r_state == WAIT);
    assign w_start    = (r_state == IDLE) && div_start;
    assign w_busy_sel = r_sel ? div_busy : divu_busy;
    assign w_commit   = w_in_wait && !w_busy_sel;
    assign w_abort    = w_in_wait && w_busy_sel && w_tc;
    assign w_new_hi   = r_sel ? div_r : divu_r;
    assign w_new_lo   = r_sel ? div_q : divu_q;

`ifdef HILO_FWD_EN
    assign w_fwd = w_commit && mf_req;
`else
    assign w_fwd = 1'b0;
`endif

    hilo_wait_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wait_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .i_clr(w_start),
        .i_en (w_in_wait && w_busy_sel),
        .o_tc (w_tc)
    );

    // WAIT ends on a commit or on the abort that follows the last permitted busy cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (div_start) w_state_nxt = WAIT;
                else           w_state_nxt = IDLE;
            end
            WAIT: begin
                if (w_commit || w_tc) w_state_nxt = IDLE;
                else                  w_state_nxt = WAIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; the divide flavour is latched when the divide is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) r_sel <= div_signed;
        end
    end

    // MT writes only land in IDLE; in WAIT they are held off by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_new_hi;
            r_lo <= w_new_lo;
        end else if (r_state == IDLE) begin
            if (mthi_we) r_hi <= mt_wdata;
            if (mtlo_we) r_lo <= mt_wdata;
        end
    end

    // Sticky abort flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_abort) begin
            r_timeout_err <= 1'b1;
        end
    end

    // Stall and MF read path; a forwarded MF sees the value committing this cycle.
    always_comb begin
        stall   = 1'b0;
        mf_data = '0;
        if (w_in_wait) stall = mthi_we || mtlo_we || div_start || (mf_req && !w_fwd);
        else           stall = 1'b0;
        if (w_fwd) mf_data = (mf_sel == HILO_SEL_HI) ? w_new_hi : w_new_lo;
        else       mf_data = (mf_sel == HILO_SEL_HI) ? r_hi : r_lo;
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hilo_commit_unit.sv
// Self-checking bench for hilo_commit_unit: the bench plays the divider and keeps
// an architectural HI/LO/error model derived from the divide and timeout rules.
module tb_hilo_commit_unit;

    localparam int W = 32;
    localparam int T = 64;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         div_start, div_signed, div_busy, divu_busy;
    logic [W-1:0] div_q, div_r, divu_q, divu_r;
    logic         mthi_we, mtlo_we, mf_req, mf_sel;
    logic [W-1:0] mt_wdata;
    logic [W-1:0] mf_data, hi, lo;
    logic         stall, timeout_err;

    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [W-1:0] m_hi, m_lo;
    logic         m_err;

    always #5 clk = ~clk;

    hilo_commit_unit #(.WIDTH(W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .div_start(div_start), .div_signed(div_signed),
        .div_q(div_q), .div_r(div_r), .divu_q(divu_q), .divu_r(divu_r),
        .div_busy(div_busy), .divu_busy(divu_busy),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_wdata(mt_wdata),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data),
        .hi(hi), .lo(lo), .stall(stall), .timeout_err(timeout_err)
    );

    // Behaviour of the external divider: truncating division, x/0 gives 0/0.
    function automatic void divmodel(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 32'd0) begin
            q = '0; r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one divide and runs it to commit/abort; updates the reference model.
    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int busy_n, input logic mf, input logic msel,
                           input logic mt, input logic [W-1:0] mtd,
                           output int n_stall, output logic [W-1:0] mf_commit,
                           output logic [W-1:0] hi_early);
        logic [W-1:0] sq, sr, uq, ur;
        int n_wait;
        bit aborted;
        divmodel(1'b1, a, b, sq, sr);
        divmodel(1'b0, a, b, uq, ur);
        aborted   = (busy_n >= T);
        n_wait    = aborted ? T : busy_n + 1;
        n_stall   = 0;
        mf_commit = '0;
        hi_early  = '0;
        div_q = sq; div_r = sr; divu_q = uq; divu_r = ur;
        div_start = 1'b1; div_signed = sgn;
        div_busy = 1'b1; divu_busy = 1'b1;
        mf_req = mf; mf_sel = msel; mthi_we = mt; mt_wdata = mtd;
        if (mt) m_hi = mtd;
        @(negedge clk);
        if (stall) n_stall++;
        @(posedge clk); #1;
        div_start  = 1'b0;
        div_signed = ~sgn;
        for (int k = 0; k < n_wait; k++) begin
            div_busy  = sgn ? (k < busy_n) : 1'b1;
            divu_busy = sgn ? 1'b1 : (k < busy_n);
            @(negedge clk);
            if (stall) n_stall++;
            if (k == 0) hi_early = hi;
            if (k == n_wait - 1) mf_commit = mf_data;
            @(posedge clk); #1;
        end
        div_busy = 1'b0; divu_busy = 1'b0;
        if (aborted) begin
            m_err = 1'b1;
        end else begin
            m_hi = sgn ? sr : ur;
            m_lo = sgn ? sq : uq;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        div_start = 1'b1; div_signed = 1'b1; div_busy = 1'b0; divu_busy = 1'b0;
        div_q = $urandom(); div_r = $urandom(); divu_q = $urandom(); divu_r = $urandom();
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_wdata = $urandom() | 32'd1;
        mf_req = 1'b1; mf_sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", lo); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_cnt++;
        total_cnt++; if (mf_data !== 32'd0) $display("FAIL reset_mf_data: got %h expected 0", mf_data); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); else pass_cnt++;
        div_start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; mf_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0; m_err = 1'b0;
    endtask

    task automatic test_div_basic();
        int ns; logic [W-1:0] mfc, he, prev;
        run_div(1'b1, 32'd100, 32'd7, 0, 1'b0, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (ns !== 0) $display("FAIL div100_stall_cycles: got %0d expected 0", ns); else pass_cnt++;
        total_cnt++; if (he !== 32'd0) $display("FAIL div100_hi_early: got %h expected 0", he); else pass_cnt++;
        total_cnt++; if (hi !== 32'd2) $display("FAIL div100_hi: got %h expected 2", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd14) $display("FAIL div100_lo: got %h expected 14", lo); else pass_cnt++;
        prev = m_hi;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (he !== prev) $display("FAIL divneg_hi_early: got %h expected %h", he, prev); else pass_cnt++;
        total_cnt++; if (hi !== 32'hFFFF_FFFF) $display("FAIL divneg_hi: got %h expected ffffffff", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFF_FFFD) $display("FAIL divneg_lo: got %h expected fffffffd", lo); else pass_cnt++;
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (hi !== 32'd1) $display("FAIL divu_hi: got %h expected 1", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h7FFF_FFFC) $display("FAIL divu_lo: got %h expected 7ffffffc", lo); else pass_cnt++;
    endtask

    task automatic test_busy_stall();
        int ns; logic [W-1:0] mfc, he, old_v, new_v; logic msel;
        msel  = ($urandom_range(0, 1) == 1);
        old_v = msel ? m_hi : m_lo;
        run_div(1'b1, $urandom(), 32'd13, 3, 1'b1, msel, 1'b0, 32'd0, ns, mfc, he);
        new_v = msel ? m_hi : m_lo;
        total_cnt++; if (ns !== (FWD ? 3 : 4)) $display("FAIL busy3_stall_cycles: got %0d expected %0d", ns, FWD ? 3 : 4); else pass_cnt++;
        total_cnt++; if (mfc !== (FWD ? new_v : old_v)) $display("FAIL busy3_mf_commit: got %h expected %h", mfc, FWD ? new_v : old_v); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL busy3_idle_stall: got %b expected 0", stall); else pass_cnt++;
        total_cnt++; if (mf_data !== new_v) $display("FAIL busy3_idle_mf: got %h expected %h", mf_data, new_v); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL busy3_hilo: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
        mf_req = 1'b0;
    endtask

    task automatic test_divzero();
        int ns; logic [W-1:0] mfc, he;
        run_div(1'b0, $urandom() | 32'd1, 32'd0, 0, 1'b0, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL divzero_hilo: got %h/%h expected 0/0", hi, lo); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL divzero_err: got %b expected 0", timeout_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int ns; logic [W-1:0] mfc, he, old_hi, old_lo;
        run_div(1'b1, $urandom(), 32'd5, T - 1, 1'b1, 1'b1, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL busy63_err: got %b expected 0", timeout_err); else pass_cnt++;
        total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL busy63_hilo: got %h/%h expected %h/%h", hi, lo, m_hi, m_lo); else pass_cnt++;
        total_cnt++; if (ns !== (FWD ? T - 1 : T)) $display("FAIL busy63_stall_cycles: got %0d expected %0d", ns, FWD ? T - 1 : T); else pass_cnt++;
        old_hi = m_hi; old_lo = m_lo;
        run_div(1'b0, $urandom(), 32'd9, T, 1'b1, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (timeout_err !== m_err) $display("FAIL tmo_err: got %b expected %b", timeout_err, m_err); else pass_cnt++;
        total_cnt++; if (hi !== old_hi || lo !== old_lo) $display("FAIL tmo_hilo: got %h/%h expected %h/%h", hi, lo, old_hi, old_lo); else pass_cnt++;
        total_cnt++; if (ns !== T) $display("FAIL tmo_stall_cycles: got %0d expected %0d", ns, T); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL tmo_idle_stall: got %b expected 0", stall); else pass_cnt++;
        mf_req = 1'b0;
        run_div(1'b1, 32'd50, 32'd8, 0, 1'b0, 1'b0, 1'b0, 32'd0, ns, mfc, he);
        total_cnt++; if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", timeout_err); else pass_cnt++;
        total_cnt++; if (hi !== 32'd2 || lo !== 32'd6) $display("FAIL tmo_then_div: got %h/%h expected 2/6", hi, lo); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_clears_err: got %b expected 0", timeout_err); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL rst_clears_hi: got %h expected 0", hi); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0; m_err = 1'b0;
    endtask

    task automatic test_mt();
        int ns; logic [W-1:0] mfc, he, d;
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        total_cnt++; if (stall !== 1'b0) $display("FAIL mt_idle_stall: got %b expected 0", stall); else pass_cnt++;
        @(posedge clk); #1;
        mthi_we = 1'b0; mtlo_we = 1'b1; mt_wdata = 32'h5A5A_5A5A;
        total_cnt++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) $display("FAIL mt_both: got %h/%h expected a5a5a5a5/a5a5a5a5", hi, lo); else pass_cnt++;
        @(posedge clk); #1;
        mtlo_we = 1'b0;
        total_cnt++; if (hi !== 32'hA5A5_A5A5 || lo !== 32'h5A5A_5A5A) $display("FAIL mtlo_only: got %h/%h expected a5a5a5a5/5a5a5a5a", hi, lo); else pass_cnt++;
        m_hi = 32'hA5A5_A5A5; m_lo = 32'h5A5A_5A5A;
        d = $urandom();
        run_div(1'b1, 32'd1000, 32'd33, 2, 1'b0, 1'b0, 1'b1, d, ns, mfc, he);
        total_cnt++; if (he !== d) $display("FAIL mt_with_start: got %h expected %h", he, d); else pass_cnt++;
        total_cnt++; if (ns !== 3) $display("FAIL mt_wait_stall_cycles: got %0d expected 3", ns); else pass_cnt++;
        total_cnt++; if (hi !== 32'd10 || lo !== 32'd30) $display("FAIL mt_wait_commit: got %h/%h expected a/1e", hi, lo); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL mt_after_commit_stall: got %b expected 0", stall); else pass_cnt++;
        @(posedge clk); #1;
        mthi_we = 1'b0;
        m_hi = d;
        total_cnt++; if (hi !== d || lo !== m_lo) $display("FAIL mt_lands_after: got %h/%h expected %h/%h", hi, lo, d, m_lo); else pass_cnt++;
    endtask

    task automatic test_random();
        int ns, busy_n, exp_ns; logic [W-1:0] mfc, he, a, b, old_v, new_v; logic sgn, mf, msel;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                mthi_we = ($urandom_range(0, 1) == 1);
                mtlo_we = ($urandom_range(0, 1) == 1);
                mt_wdata = $urandom();
                if (mthi_we) m_hi = mt_wdata;
                if (mtlo_we) m_lo = mt_wdata;
                @(posedge clk); #1;
                mthi_we = 1'b0; mtlo_we = 1'b0;
            end
            sgn    = ($urandom_range(0, 1) == 1);
            mf     = ($urandom_range(0, 1) == 1);
            msel   = ($urandom_range(0, 1) == 1);
            busy_n = $urandom_range(0, 5);
            a      = $urandom();
            b      = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(1, 40));
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            old_v = msel ? m_hi : m_lo;
            run_div(sgn, a, b, busy_n, mf, msel, 1'b0, 32'd0, ns, mfc, he);
            new_v  = msel ? m_hi : m_lo;
            exp_ns = mf ? (busy_n + 1 - (FWD ? 1 : 0)) : 0;
            total_cnt++; if (ns !== exp_ns) $display("FAIL rnd%0d_stall_cycles: got %0d expected %0d", it, ns, exp_ns); else pass_cnt++;
            total_cnt++; if (hi !== m_hi || lo !== m_lo) $display("FAIL rnd%0d_hilo: got %h/%h expected %h/%h", it, hi, lo, m_hi, m_lo); else pass_cnt++;
            total_cnt++; if (mfc !== ((FWD && mf) ? new_v : old_v)) $display("FAIL rnd%0d_mf_commit: got %h expected %h", it, mfc, (FWD && mf) ? new_v : old_v); else pass_cnt++;
            mf_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_busy_stall();
        test_divzero();
        test_timeout();
        test_mt();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
